// File: rtl/inst_fetch_pkg.sv
// Shared widths, PC step and fetch FSM encodings for the instruction-fetch stage.
package inst_fetch_pkg;
  localparam int AddrBus = 32;
  localparam int InstBus = 32;
  localparam logic [AddrBus-1:0] PCStep = 32'd4;

  typedef enum logic {
    LOOKUP = 1'b0,
    MISS   = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
module inst_fetch_icache
  import inst_fetch_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int TAG_W = AddrBus - IDX_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IDX_W-1:0]   idx,
  input  logic [TAG_W-1:0]   tag,
  input  logic               we,
  input  logic [InstBus-1:0] wdata,
  output logic               hit,
  output logic [InstBus-1:0] rdata
);
  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [DEPTH];
  logic [InstBus-1:0] data_arr [DEPTH];

  assign hit   = valid[idx] && (tag_arr[idx] == tag);
  assign rdata = data_arr[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (we) begin
      valid[idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_arr[idx]  <= tag;
      data_arr[idx] <= wdata;
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, optional direct-mapped icache (ICACHE_EN), memctrl miss handshake, redirects.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                 ICACHE_IDX_W = 8,
  parameter logic [AddrBus-1:0] RESET_PC     = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  output logic               oMEM_en,
  output logic [AddrBus-1:0] oMEM_addr,
  input  logic               iMEM_done,
  input  logic [InstBus-1:0] iMEM_inst,
  input  logic               iID_stall,
  output logic               oID_en,
  output logic [InstBus-1:0] oID_inst,
  output logic [AddrBus-1:0] oID_pc,
  input  logic               iROB_jump_en,
  input  logic [AddrBus-1:0] iROB_jump_pc
);
  fetch_state_e       state;
  logic [AddrBus-1:0] pc;
  logic               hit;
  logic [InstBus-1:0] rdata;

`ifdef ICACHE_EN
  logic [ICACHE_IDX_W-1:0]         idx;
  logic [AddrBus-ICACHE_IDX_W-3:0] tag;
  logic                            fill;

  assign idx  = pc[ICACHE_IDX_W+1:2];
  assign tag  = pc[AddrBus-1:ICACHE_IDX_W+2];
  // pc is stable throughout MISS, so the fill lands on the line that missed.
  assign fill = rdy && !iROB_jump_en && (state == MISS) && iMEM_done;

  inst_fetch_icache #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (AddrBus - ICACHE_IDX_W - 2)
  ) u_icache (
    .clk   (clk),
    .rst   (rst),
    .idx   (idx),
    .tag   (tag),
    .we    (fill),
    .wdata (iMEM_inst),
    .hit   (hit),
    .rdata (rdata)
  );
`else
  assign hit   = 1'b0;
  assign rdata = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      state     <= LOOKUP;
      oMEM_en   <= 1'b0;
      oMEM_addr <= '0;
      oID_en    <= 1'b0;
      oID_inst  <= '0;
      oID_pc    <= '0;
    end else if (rdy) begin
      oID_en <= 1'b0;
      if (iROB_jump_en) begin
        pc      <= iROB_jump_pc;
        oMEM_en <= 1'b0;
        state   <= LOOKUP;
      end else begin
        case (state)
          LOOKUP: begin
            if (!iID_stall) begin
              if (hit) begin
                oID_en   <= 1'b1;
                oID_inst <= rdata;
                oID_pc   <= pc;
                pc       <= pc + PCStep;
              end else begin
                oMEM_en   <= 1'b1;
                oMEM_addr <= pc;
                state     <= MISS;
              end
            end
          end
          MISS: begin
            // Issued regardless of iID_stall: the queue reserves one slot for this.
            if (iMEM_done) begin
              oMEM_en  <= 1'b0;
              oID_en   <= 1'b1;
              oID_inst <= iMEM_inst;
              oID_pc   <= pc;
              pc       <= pc + PCStep;
              state    <= LOOKUP;
            end
          end
          default: state <= LOOKUP;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; expectations follow whichever ICACHE_EN build is compiled.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_inst;
  logic        stall;
  logic        id_en;
  logic [31:0] id_inst, id_pc;
  logic        jump_en;
  logic [31:0] jump_pc;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [4];

  inst_fetch #(.ICACHE_IDX_W(8), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .oMEM_en      (mem_en),
    .oMEM_addr    (mem_addr),
    .iMEM_done    (mem_done),
    .iMEM_inst    (mem_inst),
    .iID_stall    (stall),
    .oID_en       (id_en),
    .oID_inst     (id_inst),
    .oID_pc       (id_pc),
    .iROB_jump_en (jump_en),
    .iROB_jump_pc (jump_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", t, obs, exp);
    end
  endtask

  task automatic wait_req(input logic [31:0] a, input string t);
    int n = 0;
    while (!mem_en && n < 20) begin
      tick();
      n++;
    end
    check({t, " req"}, {31'b0, mem_en}, 32'd1);
    check({t, " addr"}, mem_addr, a);
  endtask

  // Hold the request for dly cycles, then pulse done and check the issue cycle.
  task automatic serve(input logic [31:0] inst, input int dly, input logic [31:0] a, input string t);
    for (int i = 0; i < dly; i++) begin
      check({t, " hold en"}, {31'b0, mem_en}, 32'd1);
      check({t, " hold addr"}, mem_addr, a);
      tick();
    end
    mem_done = 1'b1;
    mem_inst = inst;
    tick();
    mem_done = 1'b0;
    mem_inst = 32'hDEAD_BEEF;
    check({t, " id_en"}, {31'b0, id_en}, 32'd1);
    check({t, " id_inst"}, id_inst, inst);
    check({t, " id_pc"}, id_pc, a);
    check({t, " en drop"}, {31'b0, mem_en}, 32'd0);
  endtask

  task automatic redirect(input logic [31:0] target);
    jump_en = 1'b1;
    jump_pc = target;
    tick();
    jump_en = 1'b0;
    check("redir en", {31'b0, mem_en}, 32'd0);
    check("redir id", {31'b0, id_en}, 32'd0);
  endtask

  initial begin
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0030_0193;
    rst = 1'b1; rdy = 1'b1; mem_done = 1'b0; mem_inst = '0;
    stall = 1'b0; jump_en = 1'b0; jump_pc = '0;
    tick();
    tick();
    check("rst mem_en", {31'b0, mem_en}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst id_en", {31'b0, id_en}, 32'd0);
    check("rst id_inst", id_inst, 32'd0);
    check("rst id_pc", id_pc, 32'd0);
    rst = 1'b0;

    // First pass over 0x0..0xC, all misses.
    for (int k = 0; k < 4; k++) begin
      wait_req(32'(k * 4), "pass1");
      serve(prog[k], (k == 0) ? 5 : 1, 32'(k * 4), "pass1");
    end
    redirect(32'h0);

    // Second pass: hits back-to-back with the cache, refetches without it.
`ifdef ICACHE_EN
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hit id_en", {31'b0, id_en}, 32'd1);
      check("hit id_inst", id_inst, prog[k]);
      check("hit id_pc", id_pc, 32'(k * 4));
      check("hit no req", {31'b0, mem_en}, 32'd0);
    end
`else
    for (int k = 0; k < 4; k++) begin
      wait_req(32'(k * 4), "pass2");
      serve(prog[k], 1, 32'(k * 4), "pass2");
    end
`endif

    // Redirect mid-miss with a coincident done: both are abandoned.
    wait_req(32'h10, "miss10");
    tick();
    tick();
    mem_done = 1'b1;
    mem_inst = 32'h1111_1111;
    redirect(32'h100);
    mem_done = 1'b0;
    tick();
    check("abandon id", {31'b0, id_en}, 32'd0);
    wait_req(32'h100, "jmp100");

    // Stall during MISS: result still issued, then no further lookups.
    stall = 1'b1;
    serve(32'h0000_0111, 2, 32'h100, "stall");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall no req", {31'b0, mem_en}, 32'd0);
      check("stall no id", {31'b0, id_en}, 32'd0);
    end
    stall = 1'b0;
    wait_req(32'h104, "unstall");

    // rdy low mid-miss: everything holds.
    tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdy hold en", {31'b0, mem_en}, 32'd1);
      check("rdy hold addr", mem_addr, 32'h104);
    end
    rdy = 1'b1;
    serve(32'h0000_0222, 1, 32'h104, "rdy");

    // Aliasing: 0x400 shares line 0 with 0x0 and evicts it.
    redirect(32'h400);
    wait_req(32'h400, "alias400");
    serve(32'h0000_0AAA, 1, 32'h400, "alias400");
    redirect(32'h0);
    wait_req(32'h0, "alias0");
    serve(prog[0], 1, 32'h0, "alias0");

    // PC wrap from 0xFFFFFFFC to 0.
    redirect(32'hFFFF_FFFC);
    wait_req(32'hFFFF_FFFC, "wrap");
    serve(32'h0000_0333, 1, 32'hFFFF_FFFC, "wrap");
`ifdef ICACHE_EN
    tick();
    check("wrap hit id_en", {31'b0, id_en}, 32'd1);
    check("wrap hit id_pc", id_pc, 32'h0);
    check("wrap hit inst", id_inst, prog[0]);
`else
    wait_req(32'h0, "wrap0");
    serve(prog[0], 1, 32'h0, "wrap0");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of memctrl's instruction port.
- Holds the architectural fetch PC and looks it up in a direct-mapped instruction cache.
- On a miss, issues a 4-byte read through memctrl's iINF_en/iINF_addr/oINF_done/oINF_inst handshake.
- Delivers one instruction per cycle with its PC to the decode/issue queue; accepts PC redirects from commit.

Parameters:
- ICACHE_IDX_W, 8, index width; the cache has 2^ICACHE_IDX_W one-word lines.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rdy  input  1  global enable; when low, all state holds.
- oMEM_en  output  1  fetch request to memctrl (drives iINF_en).
- oMEM_addr  output  32  fetch address (drives iINF_addr).
- iMEM_done  input  1  one-cycle completion pulse from memctrl (oINF_done).
- iMEM_inst  input  32  fetched word, valid while iMEM_done is high.
- iID_stall  input  1  queue almost full; at most one more entry is accepted.
- oID_en  output  1  instruction-valid pulse to decode.
- oID_inst  output  32  instruction.
- oID_pc  output  32  PC of oID_inst.
- iROB_jump_en  input  1  redirect request.
- iROB_jump_pc  input  32  redirect target.

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, state=LOOKUP, oMEM_en=0, oMEM_addr=0, oID_en=0, oID_inst=0, oID_pc=0, all valid bits=0. Data and tag arrays are not reset.
- rdy low and rst low: every register holds, including oMEM_en, so memctrl's stage count is not disturbed.
- Address split: index=pc[ICACHE_IDX_W+1:2], tag=pc[31:ICACHE_IDX_W+2]. pc[1:0] is always 0.
- Every cycle, oID_en defaults to 0; it is high for exactly one cycle per delivered instruction.
- State LOOKUP, when iID_stall=0:
  - Hit (valid[index] and tag match): next cycle oID_en=1, oID_inst=data[index], oID_pc=pc; pc<=pc+4. Hit throughput is 1 instruction per cycle.
  - Miss: oMEM_en<=1, oMEM_addr<=pc, go to MISS.
- State LOOKUP, when iID_stall=1: no lookup and no request.
- State MISS:
  - oMEM_en and oMEM_addr are held constant until iMEM_done is sampled high.
  - At that edge: oMEM_en<=0, valid/tag/data[index] are written, oID_en<=1 with oID_inst=iMEM_inst and oID_pc=pc, pc<=pc+4, go to LOOKUP.
  - The result is issued even if iID_stall=1 (that is the one permitted extra entry).
  - Miss latency: the result is issued in the cycle after iMEM_done. Data-port priority inside memctrl may lengthen the wait; this block simply waits.
- Redirect: iROB_jump_en has priority over everything in the same cycle.
  - pc<=iROB_jump_pc, oID_en<=0, oMEM_en<=0, state<=LOOKUP.
  - Any in-flight miss is abandoned. Dropping oMEM_en resets memctrl's stage.
  - An iMEM_done arriving in the same cycle as a redirect is discarded entirely: no cache write and no issue.
- One spurious extra memctrl cycle after oMEM_en falls is tolerated; its output is ignored because the state is no longer MISS.
- PC wrap: 32'hFFFFFFFC+4 wraps to 0 with no flag.

Optional Feature:
- ICACHE_EN defined: behaviour as above.
- ICACHE_EN undefined:
  - No arrays and no valid bits are instantiated.
  - Every LOOKUP is treated as a miss, giving one memctrl transaction per instruction.
  - Ports and handshake are unchanged.

Decomposition:
- Shared package/config holds:
  - AddrBus and InstBus widths.
  - PCStep (=4).
  - The state encodings for LOOKUP and MISS.
- Natural sub-module: icache, a direct-mapped array with valid/tag/data.
  - Combinational hit/rdata on the lookup index.
  - Synchronous write port.
  - Synchronous clear of the valid bits on rst.
  - Omitted entirely when ICACHE_EN is undefined.

Test Plan:
- Reset, then memory returns 32'h00000013 at address 0 after 5 cycles -> oMEM_addr=0 is held until done; next cycle oID_en=1, oID_inst=32'h13, oID_pc=0; pc=4.
- Loop back to 0 via a redirect (iROB_jump_en=1, iROB_jump_pc=0) after the first pass over 0x0..0xC -> second pass hits with no oMEM_en and 4 consecutive oID_en pulses (ICACHE_EN defined).
- Redirect to 0x100 while in MISS at 0x10 -> oMEM_en drops the next cycle, no oID_en for 0x10, next request oMEM_addr=0x100.
- iID_stall=1 while in MISS -> the miss result is still issued once; no further lookups until stall=0.
- rdy=0 for 3 cycles mid-miss -> oMEM_en/oMEM_addr are held and pc is unchanged; completion proceeds normally after rdy=1.
- Aliasing: fetch 0x0, then 0x400 (ICACHE_IDX_W=8), then 0x0 -> the third access misses again and the line is refilled.
